// File: rtl/fb_mem_responder.sv
// Framebuffer memory responder: one 32-bit-word RAM shared by drawing-engine
// read/write accesses and a priority video scan-out read port.
module fb_mem_responder #(
  parameter int ADDR_W      = 18,
  parameter int MAX_VID_RUN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        de_req,
  output logic        de_ack,
  input  logic [17:0] de_addr,
  input  logic [3:0]  de_nbyte,
  input  logic        de_rnw,
  input  logic [31:0] de_w_data,
  output logic [31:0] de_r_data,
  input  logic        vid_req,
  input  logic [17:0] vid_addr,
  output logic        vid_ack,
  output logic [31:0] vid_data
);

  localparam int RUN_W = $clog2(MAX_VID_RUN + 1);

  typedef enum logic [2:0] {
    IDLE,
    DE_WR_ACK,
    DE_RD,
    DE_RD_ACK,
    VID_RD,
    VID_ACK
  } state_t;

  state_t             state_q;
  logic [RUN_W-1:0]   run_q;
  logic               de_ack_q;
  logic               vid_ack_q;
  logic [31:0]        de_r_data_q;
  logic [31:0]        vid_data_q;
  logic [31:0]        rd_q;

  logic [31:0]        mem [(1 << ADDR_W)];

  logic [ADDR_W-1:0]  de_a;
  logic [ADDR_W-1:0]  vid_a;
  logic [ADDR_W-1:0]  rd_a;
  logic               de_elig;
  logic               vid_elig;
  logic               grant_vid;
  logic               grant_de;
  logic               wr_en;
  logic               rd_en;
  logic               unused_addr_bits;

  assign de_a  = de_addr[ADDR_W-1:0];
  assign vid_a = vid_addr[ADDR_W-1:0];
  assign unused_addr_bits = ^{de_addr, vid_addr};

  // An initiator still holding req during its own ack cycle is not eligible.
  always_comb begin
    de_elig   = de_req & ~de_ack_q;
    vid_elig  = vid_req & ~vid_ack_q;
    grant_vid = 1'b0;
    grant_de  = 1'b0;
    if (state_q == IDLE) begin
      grant_vid = vid_elig & (~de_elig | (run_q != RUN_W'(MAX_VID_RUN)));
      grant_de  = de_elig & ~grant_vid;
    end
    wr_en = ~rst & grant_de & ~de_rnw;
    rd_en = ~rst & (grant_vid | (grant_de & de_rnw));
    rd_a  = grant_vid ? vid_a : de_a;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (!de_nbyte[i]) mem[de_a][8*i +: 8] <= de_w_data[8*i +: 8];
      end
    end
    if (rd_en) rd_q <= mem[rd_a];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      run_q       <= '0;
      de_ack_q    <= 1'b0;
      vid_ack_q   <= 1'b0;
      de_r_data_q <= '0;
      vid_data_q  <= '0;
    end else begin
      de_ack_q  <= 1'b0;
      vid_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!de_req || grant_de) run_q <= '0;
          else if (grant_vid)      run_q <= run_q + 1'b1;
          if (grant_vid) begin
            state_q <= VID_RD;
          end else if (grant_de) begin
            if (de_rnw) begin
              state_q <= DE_RD;
            end else begin
              state_q  <= DE_WR_ACK;
              de_ack_q <= 1'b1;
            end
          end
        end
        DE_WR_ACK: state_q <= IDLE;
        DE_RD: begin
          de_r_data_q <= rd_q;
          de_ack_q    <= 1'b1;
          state_q     <= DE_RD_ACK;
        end
        DE_RD_ACK: state_q <= IDLE;
        VID_RD: begin
          vid_data_q <= rd_q;
          vid_ack_q  <= 1'b1;
          state_q    <= VID_ACK;
        end
        VID_ACK: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign de_ack    = de_ack_q;
  assign vid_ack   = vid_ack_q;
  assign de_r_data = de_r_data_q;
  assign vid_data  = vid_data_q;

endmodule

// File: tb/tb_fb_mem_responder.sv
// Directed/randomized bench for fb_mem_responder against a word-array memory model.
module tb_fb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        de_req;
  logic        de_ack;
  logic [17:0] de_addr;
  logic [3:0]  de_nbyte;
  logic        de_rnw;
  logic [31:0] de_w_data;
  logic [31:0] de_r_data;
  logic        vid_req;
  logic [17:0] vid_addr;
  logic        vid_ack;
  logic [31:0] vid_data;

  int tests = 0;
  int failed = 0;
  int de_ack_cnt = 0;
  bit coincide = 1'b0;

  logic [31:0] model [1024];
  bit          init_w [1024];

  fb_mem_responder #(.ADDR_W(10), .MAX_VID_RUN(4)) dut (
    .clk(clk), .rst(rst),
    .de_req(de_req), .de_ack(de_ack), .de_addr(de_addr), .de_nbyte(de_nbyte),
    .de_rnw(de_rnw), .de_w_data(de_w_data), .de_r_data(de_r_data),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (de_ack === 1'b1) de_ack_cnt++;
    if (de_ack === 1'b1 && vid_ack === 1'b1) coincide = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] nb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (!nb[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drawing access from IDLE with video quiet; checks latency and one-cycle ack.
  task automatic de_op(input string tag, input bit rnw, input logic [17:0] a,
                       input logic [3:0] nb, input logic [31:0] wd, output logic [31:0] rd);
    int n;
    n = 0;
    de_rnw = rnw; de_addr = a; de_nbyte = nb; de_w_data = wd; de_req = 1'b1;
    do begin tick(); n++; end while (de_ack !== 1'b1 && n < 16);
    chk({tag, "_ack"}, 32'(de_ack), 32'd1);
    chk({tag, "_lat"}, n, rnw ? 32'd2 : 32'd1);
    rd = de_r_data;
    if (!rnw) begin
      model[a[9:0]] = merge(model[a[9:0]], wd, nb);
    end
    tick();
    chk({tag, "_pulse"}, 32'(de_ack), 32'd0);
    de_req = 1'b0;
  endtask

  task automatic de_wr(input string tag, input logic [17:0] a, input logic [3:0] nb,
                       input logic [31:0] wd);
    logic [31:0] d;
    de_op(tag, 1'b0, a, nb, wd, d);
    if (nb == 4'b0000) init_w[a[9:0]] = 1'b1;
  endtask

  task automatic de_rd_chk(input string tag, input logic [17:0] a);
    logic [31:0] d;
    de_op(tag, 1'b1, a, 4'hF, 32'h0, d);
    chk({tag, "_data"}, d, model[a[9:0]]);
  endtask

  logic [31:0] lanes_exp [3];
  logic [3:0]  lanes_nb  [3];

  initial begin
    logic [31:0] d, pd;
    logic [17:0] a;
    int c0, k, cyc, n;

    rst = 1'b1; de_req = 1'b0; vid_req = 1'b0; de_addr = '0; de_nbyte = 4'hF;
    de_rnw = 1'b0; de_w_data = '0; vid_addr = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_de_ack", 32'(de_ack), 32'd0);
    chk("rst_vid_ack", 32'(vid_ack), 32'd0);
    chk("rst_de_r_data", de_r_data, 32'd0);
    chk("rst_vid_data", vid_data, 32'd0);
    tick();

    // Single partial write
    de_wr("w10_full", 18'h00010, 4'b0000, 32'h0000_0000);
    de_wr("w10_b0", 18'h00010, 4'b1110, 32'h5555_5555);
    de_op("r10", 1'b1, 18'h00010, 4'hF, 32'h0, d);
    chk("r10_data", d, 32'h0000_0055);

    // Each byte lane in turn
    lanes_nb[0] = 4'b1101; lanes_exp[0] = 32'hFFFF_AAFF;
    lanes_nb[1] = 4'b1011; lanes_exp[1] = 32'hFFAA_AAFF;
    lanes_nb[2] = 4'b0111; lanes_exp[2] = 32'hAAAA_AAFF;
    de_wr("w20_full", 18'h00020, 4'b0000, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) begin
      de_wr("w20_lane", 18'h00020, lanes_nb[i], 32'hAAAA_AAAA);
      de_op("r20_lane", 1'b1, 18'h00020, 4'hF, 32'h0, d);
      chk("r20_lane_data", d, lanes_exp[i]);
    end
    de_wr("w20_none", 18'h00020, 4'b1111, 32'h1234_5678);
    de_op("r20_none", 1'b1, 18'h00020, 4'hF, 32'h0, d);
    chk("r20_none_data", d, 32'hAAAA_AAFF);

    // Handshake: drop req on edge after ack, re-raise 2 cycles later
    c0 = de_ack_cnt;
    for (int i = 0; i < 8; i++) begin
      de_wr("hs_wr", 18'h00100 + 18'(i), 4'b0000, $urandom);
      tick();
      tick();
    end
    chk("hs_ack_count", de_ack_cnt - c0, 32'd8);
    for (int i = 0; i < 8; i++) de_rd_chk("hs_rd", 18'h00100 + 18'(i));

    // Randomized partial writes with model readback
    for (int i = 0; i < 8; i++) begin
      a = 18'h00200 + 18'($urandom_range(0, 15));
      if (!init_w[a[9:0]]) de_wr("rnd_full", a, 4'b0000, $urandom);
      de_wr("rnd_part", a, 4'($urandom_range(0, 15)), $urandom);
      de_rd_chk("rnd_rd", a);
    end

    // Standalone video read
    vid_addr = 18'h00103; vid_req = 1'b1; n = 0;
    do begin tick(); n++; end while (vid_ack !== 1'b1 && n < 16);
    vid_req = 1'b0;
    chk("vid_lat", n, 32'd2);
    chk("vid_data", vid_data, model[10'h103]);
    tick(); tick();

    // Req dropped right after accept still completes
    de_rnw = 1'b1; de_addr = 18'h00101; de_req = 1'b1;
    tick();
    de_req = 1'b0;
    tick();
    chk("drop_ack", 32'(de_ack), 32'd1);
    chk("drop_data", de_r_data, model[10'h101]);
    tick(); tick();

    // Video priority with anti-starvation, de_req held continuously
    pd = $urandom;
    de_rnw = 1'b0; de_addr = 18'h00040; de_nbyte = 4'b0000; de_w_data = pd; de_req = 1'b1;
    vid_addr = 18'h00020; vid_req = 1'b1;
    k = 0; cyc = 0;
    while (k < 20 && cyc < 400) begin
      tick();
      cyc++;
      if (de_ack === 1'b1 || vid_ack === 1'b1) begin
        chk("prio_order", 32'({de_ack, vid_ack}), (k % 5 == 4) ? 32'd2 : 32'd1);
        if (vid_ack === 1'b1) chk("prio_vid_data", vid_data, 32'hAAAA_AAFF);
        k++;
      end
    end
    de_req = 1'b0; vid_req = 1'b0;
    model[10'h040] = pd;
    chk("prio_done", k, 32'd20);
    tick(); tick();
    chk("no_coincide", 32'(coincide), 32'd0);
    de_rd_chk("prio_rd40", 18'h00040);

    // Reset during a read
    de_rnw = 1'b1; de_addr = 18'h00020; de_req = 1'b1;
    tick();
    rst = 1'b1; de_req = 1'b0;
    c0 = de_ack_cnt;
    tick();
    rst = 1'b0;
    chk("rstmid_ack", 32'(de_ack), 32'd0);
    chk("rstmid_data", de_r_data, 32'd0);
    repeat (3) tick();
    chk("rstmid_noack", de_ack_cnt - c0, 32'd0);
    de_rd_chk("rstmid_fresh", 18'h00020);

    // Address wrap at ADDR_W=10
    de_wr("wrap_wr", 18'h00400, 4'b0000, $urandom);
    de_rd_chk("wrap_rd", 18'h00000);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
